// File: rtl/case_select_monitor_pkg.sv
// -----------------------------------------------------------------------------
// case_select_pkg
// Shared definitions for the case-select monitor:
//   - decoder flavour encodings carried on the mode input
//   - monitor FSM state encodings
//   - golden decode table for the 2-bit-select / 4-bit-data case decoders
// -----------------------------------------------------------------------------
package case_select_pkg;

    // Decoder flavour (mode input). Value 3 is reserved and behaves as unique.
    localparam logic [1:0] MODE_UNIQUE   = 2'd0;
    localparam logic [1:0] MODE_UNIQUE0  = 2'd1;
    localparam logic [1:0] MODE_PRIORITY = 2'd2;

    // Monitor FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    // Reference decode: select 3 is the no-match default and must yield 0.
    function automatic logic [3:0] golden_data(input logic [1:0] sel);
        logic [3:0] g;
        case (sel)
            2'd0:    g = 4'hA;
            2'd1:    g = 4'h6;
            2'd2:    g = 4'h3;
            default: g = 4'h0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/case_mon_sat_counter.sv
// -----------------------------------------------------------------------------
// case_mon_sat_counter
// Saturating up-counter with synchronous clear. Holds at all-ones.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (zeroes the count)
//   clr  - synchronous clear (zeroes the count, wins over inc)
//   inc  - increment request
//   cnt  - current count
// -----------------------------------------------------------------------------
module case_mon_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/case_select_monitor.sv
// -----------------------------------------------------------------------------
// case_select_monitor
// Downstream checker for 2-bit-select / 4-bit-data case decoders (unique,
// unique0, priority). Each valid select/data pair is registered, compared
// against the golden decode table, and no-match selects are classified as
// violations according to the decoder flavour. Saturating match/violation
// counts and sticky flags are kept.
//
// Optional feature (macro CASE_SELECT_MONITOR_HALT_EN): the first violation
// halts the monitor; while halted out_valid is 0, counters freeze and stickies
// hold. Only clear or rst leaves HALT.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   in_valid        - select/data pair valid this cycle
//   select, data    - decoder select and decoder output
//   mode            - 0 unique, 1 unique0, 2 priority, 3 reserved (as unique)
//   clear           - synchronous clear of counters, stickies and FSM
//   out_valid       - registered in_valid
//   out_data        - registered data
//   violation       - one-cycle pulse aligned with out_valid
//   mismatch        - one-cycle pulse aligned with out_valid
//   viol_sticky     - set by any counted violation
//   mism_sticky     - set by any counted mismatch
//   match_cnt       - saturating count of pairs matching golden
//   viol_cnt        - saturating count of violations
// -----------------------------------------------------------------------------
module case_select_monitor
    import case_select_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       select,
    input  logic [3:0]       data,
    input  logic [1:0]       mode,
    input  logic             clear,
    output logic             out_valid,
    output logic [3:0]       out_data,
    output logic             violation,
    output logic             mismatch,
    output logic             viol_sticky,
    output logic             mism_sticky,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] viol_cnt
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       accept;
    logic       viol_c;
    logic       mism_c;
    logic       count_en;

    logic       vld_p1;
    logic [3:0] data_p1;
    logic       viol_p1;
    logic       mism_p1;

    // ---- stage p0: classify the incoming pair ----
    // Under unique0 a no-match select is legal; every other flavour flags it.
    assign viol_c = (select == 2'd3) && (mode != MODE_UNIQUE0);
    assign mism_c = (data != golden_data(select));

`ifdef CASE_SELECT_MONITOR_HALT_EN
    // A pair arriving with clear is still reported even while halted.
    assign accept = in_valid && ((state_q != ST_HALT) || clear);
`else
    assign accept = in_valid;
`endif

    // clear wins over same-cycle events for counters and stickies.
    assign count_en = accept && !clear;

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_d = ST_RUN;
`ifdef CASE_SELECT_MONITOR_HALT_EN
                        if (viol_c) state_d = ST_HALT;
`endif
                    end
                end
                ST_RUN: begin
`ifdef CASE_SELECT_MONITOR_HALT_EN
                    if (in_valid && viol_c) state_d = ST_HALT;
`endif
                end
                ST_HALT: begin
`ifdef CASE_SELECT_MONITOR_HALT_EN
                    state_d = ST_HALT;
`else
                    state_d = ST_IDLE;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= 4'h0;
            viol_p1 <= 1'b0;
            mism_p1 <= 1'b0;
        end else begin
            vld_p1  <= accept;
            data_p1 <= accept ? data : 4'h0;
            viol_p1 <= accept && viol_c;
            mism_p1 <= accept && mism_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            viol_sticky <= 1'b0;
            mism_sticky <= 1'b0;
        end else begin
            if (count_en && viol_c) viol_sticky <= 1'b1;
            if (count_en && mism_c) mism_sticky <= 1'b1;
        end
    end

    case_mon_sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (count_en && !mism_c),
        .cnt (match_cnt)
    );

    case_mon_sat_counter #(.W(CNT_W)) u_viol_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (count_en && viol_c),
        .cnt (viol_cnt)
    );

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign violation = viol_p1;
    assign mismatch  = mism_p1;

endmodule

// File: tb/tb_case_select_monitor.sv
// -----------------------------------------------------------------------------
// tb_case_select_monitor
// Directed bench for case_select_monitor. A second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_case_select_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] select = 2'd0;
    logic [3:0] data = 4'h0;
    logic [1:0] mode = 2'd0;
    logic       clear = 1'b0;

    logic       out_valid, violation, mismatch, viol_sticky, mism_sticky;
    logic [3:0] out_data;
    logic [7:0] match_cnt, viol_cnt;

    logic       s_out_valid, s_violation, s_mismatch, s_viol_sticky, s_mism_sticky;
    logic [3:0] s_out_data;
    logic [1:0] s_match_cnt, s_viol_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    case_select_monitor #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .select(select), .data(data),
        .mode(mode), .clear(clear), .out_valid(out_valid), .out_data(out_data),
        .violation(violation), .mismatch(mismatch), .viol_sticky(viol_sticky),
        .mism_sticky(mism_sticky), .match_cnt(match_cnt), .viol_cnt(viol_cnt)
    );

    case_select_monitor #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .select(select), .data(data),
        .mode(mode), .clear(clear), .out_valid(s_out_valid), .out_data(s_out_data),
        .violation(s_violation), .mismatch(s_mismatch), .viol_sticky(s_viol_sticky),
        .mism_sticky(s_mism_sticky), .match_cnt(s_match_cnt), .viol_cnt(s_viol_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; return just after the
    // rising edge so the registered response to this cycle is visible.
    task automatic step(input logic v, input logic [1:0] s, input logic [3:0] d,
                        input logic [1:0] m, input logic c);
        @(negedge clk);
        in_valid = v;
        select   = s;
        data     = d;
        mode     = m;
        clear    = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic vi, input logic mi,
                           input logic [7:0] mc, input logic [7:0] vc);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".violation"}, 32'(violation), 32'(vi));
        chk({tag, ".mismatch"},  32'(mismatch),  32'(mi));
        chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(mc));
        chk({tag, ".viol_cnt"},  32'(viol_cnt),  32'(vc));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        step(1'b1, 2'd3, 4'h7, 2'd0, 1'b0);
        step(1'b1, 2'd3, 4'h7, 2'd0, 1'b0);
        chk_out("reset", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("reset.out_data", 32'(out_data), 32'h0);
        chk("reset.viol_sticky", 32'(viol_sticky), 32'h0);
        chk("reset.mism_sticky", 32'(mism_sticky), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Good pairs back-to-back, mode unique
        step(1'b1, 2'd0, 4'hA, 2'd0, 1'b0);
        chk_out("good0", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
        chk("good0.out_data", 32'(out_data), 32'hA);
        step(1'b1, 2'd1, 4'h6, 2'd0, 1'b0);
        chk_out("good1", 1'b1, 1'b0, 1'b0, 8'd2, 8'd0);
        chk("good1.out_data", 32'(out_data), 32'h6);
        step(1'b1, 2'd2, 4'h3, 2'd0, 1'b0);
        chk_out("good2", 1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        chk("good2.out_data", 32'(out_data), 32'h3);
        chk("good2.mism_sticky", 32'(mism_sticky), 32'h0);

        // No-match select under unique: violation, data still matches golden 0
        step(1'b1, 2'd3, 4'h0, 2'd0, 1'b0);
        chk_out("viol_unique", 1'b1, 1'b1, 1'b0, 8'd4, 8'd1);
        chk("viol_unique.viol_sticky", 32'(viol_sticky), 32'h1);

        // Same under unique0: legal
        step(1'b1, 2'd3, 4'h0, 2'd1, 1'b0);
        chk_out("nomatch_unique0", 1'b1, 1'b0, 1'b0, 8'd5, 8'd1);

        // Wrong data under priority: mismatch only
        step(1'b1, 2'd1, 4'h5, 2'd2, 1'b0);
        chk_out("mism_prio", 1'b1, 1'b0, 1'b1, 8'd5, 8'd1);
        chk("mism_prio.mism_sticky", 32'(mism_sticky), 32'h1);
        chk("mism_prio.out_data", 32'(out_data), 32'h5);

        // Select 3 with nonzero data in priority: violation and mismatch
        step(1'b1, 2'd3, 4'h7, 2'd2, 1'b0);
        chk_out("viol_mism", 1'b1, 1'b1, 1'b1, 8'd5, 8'd2);

        // Idle cycle: pulses must drop with out_valid
        step(1'b0, 2'd3, 4'h7, 2'd0, 1'b0);
        chk_out("idle", 1'b0, 1'b0, 1'b0, 8'd5, 8'd2);
        chk("idle.viol_sticky", 32'(viol_sticky), 32'h1);

        // Reserved mode behaves as unique; three more violations
        step(1'b1, 2'd3, 4'h0, 2'd3, 1'b0);
        chk_out("viol_resv", 1'b1, 1'b1, 1'b0, 8'd6, 8'd3);
        step(1'b1, 2'd3, 4'h0, 2'd0, 1'b0);
        step(1'b1, 2'd3, 4'h0, 2'd0, 1'b0);
        chk_out("viol5", 1'b1, 1'b1, 1'b0, 8'd8, 8'd5);
        chk("sat.viol_cnt", 32'(s_viol_cnt), 32'd3);
        chk("sat.match_cnt", 32'(s_match_cnt), 32'd3);

        // Violation concurrent with clear: pulse fires, counters/stickies zero
        step(1'b1, 2'd3, 4'h0, 2'd0, 1'b1);
        chk_out("viol_clear", 1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        chk("viol_clear.viol_sticky", 32'(viol_sticky), 32'h0);
        chk("viol_clear.mism_sticky", 32'(mism_sticky), 32'h0);
        chk("viol_clear.sat_viol_cnt", 32'(s_viol_cnt), 32'd0);

        step(1'b1, 2'd0, 4'hA, 2'd0, 1'b0);
        chk_out("after_clear", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);

        // Reset mid-stream discards the in-flight pair
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        select   = 2'd3;
        data     = 4'h9;
        mode     = 2'd0;
        clear    = 1'b0;
        @(posedge clk);
        #1;
        chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("rst_mid.out_data", 32'(out_data), 32'h0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

`ifdef CASE_SELECT_MONITOR_HALT_EN
        // First violation is reported, then the monitor halts
        step(1'b1, 2'd3, 4'h0, 2'd0, 1'b0);
        chk_out("halt_viol", 1'b1, 1'b1, 1'b0, 8'd1, 8'd1);
        step(1'b1, 2'd0, 4'hA, 2'd0, 1'b0);
        step(1'b1, 2'd1, 4'h6, 2'd0, 1'b0);
        step(1'b1, 2'd2, 4'h3, 2'd0, 1'b0);
        chk_out("halted", 1'b0, 1'b0, 1'b0, 8'd1, 8'd1);
        chk("halted.viol_sticky", 32'(viol_sticky), 32'h1);
        step(1'b0, 2'd0, 4'h0, 2'd0, 1'b1);
        step(1'b1, 2'd0, 4'hA, 2'd0, 1'b0);
        chk_out("unhalt", 1'b1, 1'b0, 1'b0, 8'd1, 8'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
